// File: rtl/pmem_arb_structs.sv
// Shared types for the physical-memory arbiter: FSM state, grant owner and the
// latched request that drives the pmem_* port.
package pmem_arb_structs;

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} arb_state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] wdata;
  } pmem_req_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while fetch was waiting; force_o tells
// the arbiter that fetch must win the next arbitration.
module arb_starve_ctr #(
  parameter int unsigned Limit = 4,
  parameter int unsigned CntW  = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic force_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < CntW'(Limit))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_o = (cnt_q >= CntW'(Limit));

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates the single pmem port between instruction fetch and the data side.
// Define PMEM_ARB_STARVE_GUARD_EN to stop data traffic from starving fetch.
module pmem_arbiter
  import pmem_arb_structs::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp,
  output logic        arb_busy
);

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15) || ((1 << CNT_W) <= STARVE_LIMIT)) begin : g_bad_cfg
    $error("pmem_arbiter: illegal STARVE_LIMIT/CNT_W combination");
  end

  arb_state_t  state_d, state_q;
  pmem_req_t   req_d, req_q;
  owner_t      winner;
  logic [31:0] i_rdata_d, i_rdata_q;
  logic [31:0] d_rdata_d, d_rdata_q;
  logic        d_req;
  logic        force_i;

  assign d_req = d_read | d_write;

`ifdef PMEM_ARB_STARVE_GUARD_EN
  logic starve_force;
  logic starve_inc;
  logic starve_clr;

  assign starve_inc = (state_q == IDLE) && (winner == OWN_D) && i_read;
  assign starve_clr = (state_q == IDLE) && ((winner == OWN_I) || !i_read);

  arb_starve_ctr #(
    .Limit(STARVE_LIMIT),
    .CntW (CNT_W)
  ) u_starve_ctr (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (starve_inc),
    .clr_i  (starve_clr),
    .force_o(starve_force)
  );

  assign force_i = i_read & starve_force;
`else
  assign force_i = 1'b0;
`endif

  always_comb begin
    winner = OWN_NONE;
    if (d_req && !force_i) begin
      winner = OWN_D;
    end else if (i_read) begin
      winner = OWN_I;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    unique case (state_q)
      IDLE: begin
        unique case (winner)
          OWN_D: begin
            state_d = GRANT_D;
            // A simultaneous read+write is issued as a write.
            req_d = '{read: d_read & ~d_write, write: d_write,
                      address: d_address, wdata: d_wdata};
          end
          OWN_I: begin
            state_d = GRANT_I;
            req_d   = '{read: 1'b1, write: 1'b0, address: i_address, wdata: 32'h0};
          end
          default: ;
        endcase
      end
      GRANT_I, GRANT_D: begin
        if (pmem_resp) begin
          state_d     = IDLE;
          req_d.read  = 1'b0;
          req_d.write = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign i_resp = (state_q == GRANT_I) && pmem_resp;
  assign d_resp = (state_q == GRANT_D) && pmem_resp;

  always_comb begin
    i_rdata_d = i_resp ? pmem_rdata : i_rdata_q;
    d_rdata_d = d_resp ? pmem_rdata : d_rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Response data is forwarded in the resp cycle, then held from the register.
  assign i_rdata      = i_resp ? pmem_rdata : i_rdata_q;
  assign d_rdata      = d_resp ? pmem_rdata : d_rdata_q;
  assign pmem_read    = req_q.read;
  assign pmem_write   = req_q.write;
  assign pmem_address = req_q.address;
  assign pmem_wdata   = req_q.wdata;
  assign arb_busy     = (state_q != IDLE);

`ifndef SYNTHESIS
  a_no_rw_collision: assert property (@(posedge clk) disable iff (!rst)
    !((state_q == IDLE) && d_read && d_write))
    else $warning("pmem_arbiter: d_read and d_write both high, issuing write");
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: hand-computed expectations for fetch, data,
// priority, starvation, mid-grant address change, async reset and rw collision.
module tb_pmem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;
  logic        arb_busy;

  int unsigned n_checks;
  int unsigned n_errors;

  pmem_arbiter #(
    .STARVE_LIMIT(4),
    .CNT_W       (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_read      (i_read),
    .i_address   (i_address),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_address   (d_address),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp),
    .arb_busy    (arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory answers in the current cycle; outputs are sampled after settling.
  task automatic mem_respond(input logic [31:0] data);
    pmem_rdata = data;
    pmem_resp  = 1'b1;
    #1;
  endtask

  int unsigned d_grants;
  logic        i_seen;
  int unsigned exp_d_grants;
  logic        exp_i_seen;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b0;
    i_read     = 1'b0;
    i_address  = 32'h0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_address  = 32'h0;
    d_wdata    = 32'h0;
    pmem_rdata = 32'h0;
    pmem_resp  = 1'b0;

    step();
    step();
    check_eq("rst_busy", {31'h0, arb_busy}, 32'h0);
    check_eq("rst_strobes", {30'h0, pmem_read, pmem_write}, 32'h0);
    check_eq("rst_addr", pmem_address, 32'h0);
    check_eq("rst_resps", {30'h0, i_resp, d_resp}, 32'h0);
    rst = 1'b1;
    step();
    check_eq("post_rst_busy", {31'h0, arb_busy}, 32'h0);

    // Single fetch
    i_read    = 1'b1;
    i_address = 32'h60;
    step();
    check_eq("fetch_read", {31'h0, pmem_read}, 32'h1);
    check_eq("fetch_addr", pmem_address, 32'h60);
    check_eq("fetch_busy", {31'h0, arb_busy}, 32'h1);
    mem_respond(32'h0000_0013);
    check_eq("fetch_resp", {31'h0, i_resp}, 32'h1);
    check_eq("fetch_rdata", i_rdata, 32'h13);
    check_eq("fetch_no_dresp", {31'h0, d_resp}, 32'h0);
    step();
    pmem_resp = 1'b0;
    i_read    = 1'b0;
    #1;
    check_eq("fetch_done_busy", {31'h0, arb_busy}, 32'h0);
    check_eq("fetch_done_read", {31'h0, pmem_read}, 32'h0);
    check_eq("fetch_rdata_hold", i_rdata, 32'h13);
    step();

    // Simultaneous requests: data first
    i_read    = 1'b1;
    i_address = 32'h100;
    d_write   = 1'b1;
    d_address = 32'h2000;
    d_wdata   = 32'hDEAD_BEEF;
    step();
    check_eq("prio_write", {30'h0, pmem_read, pmem_write}, 32'h1);
    check_eq("prio_addr", pmem_address, 32'h2000);
    check_eq("prio_wdata", pmem_wdata, 32'hDEAD_BEEF);
    mem_respond(32'h0);
    check_eq("prio_dresp", {30'h0, i_resp, d_resp}, 32'h1);
    step();
    pmem_resp = 1'b0;
    d_write   = 1'b0;
    #1;
    check_eq("prio_idle_gap", {31'h0, arb_busy}, 32'h0);
    step();
    check_eq("prio_fetch_read", {31'h0, pmem_read}, 32'h1);
    check_eq("prio_fetch_addr", pmem_address, 32'h100);
    mem_respond(32'h0000_0093);
    check_eq("prio_fetch_resp", {30'h0, i_resp, d_resp}, 32'h2);
    step();
    pmem_resp = 1'b0;
    i_read    = 1'b0;
    step();

    // Address change during a grant is ignored
    d_read    = 1'b1;
    d_address = 32'h40;
    step();
    d_address = 32'h80;
    step();
    check_eq("hold_addr", pmem_address, 32'h40);
    check_eq("hold_read", {31'h0, pmem_read}, 32'h1);
    mem_respond(32'hA5A5_0001);
    check_eq("hold_dresp", {31'h0, d_resp}, 32'h1);
    check_eq("hold_drdata", d_rdata, 32'hA5A5_0001);
    check_eq("hold_irdata", i_rdata, 32'h93);
    step();
    pmem_resp = 1'b0;
    d_read    = 1'b0;
    step();

    // Starvation: fetch waits while data keeps requesting
    i_read    = 1'b1;
    i_address = 32'h200;
    d_read    = 1'b1;
    d_address = 32'h300;
    d_grants  = 0;
    i_seen    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (pmem_read && (pmem_address == 32'h200)) i_seen = 1'b1;
      else if (pmem_read && (pmem_address == 32'h300)) d_grants++;
      mem_respond(32'h0);
      step();
      pmem_resp = 1'b0;
      if (i_seen) break;
    end
    i_read = 1'b0;
    d_read = 1'b0;
`ifdef PMEM_ARB_STARVE_GUARD_EN
    exp_d_grants = 4;
    exp_i_seen   = 1'b1;
`else
    exp_d_grants = 8;
    exp_i_seen   = 1'b0;
`endif
    check_eq("starve_d_grants", d_grants, exp_d_grants);
    check_eq("starve_i_seen", {31'h0, i_seen}, {31'h0, exp_i_seen});
    step();

    // Async reset mid-grant
    d_write   = 1'b1;
    d_address = 32'h500;
    d_wdata   = 32'h1234;
    step();
    check_eq("arst_pre_write", {31'h0, pmem_write}, 32'h1);
    #2;
    rst       = 1'b0;
    pmem_resp = 1'b1;
    #1;
    check_eq("arst_strobes", {30'h0, pmem_read, pmem_write}, 32'h0);
    check_eq("arst_busy", {31'h0, arb_busy}, 32'h0);
    check_eq("arst_addr", pmem_address, 32'h0);
    check_eq("arst_no_dresp", {30'h0, i_resp, d_resp}, 32'h0);
    d_write   = 1'b0;
    pmem_resp = 1'b0;
    step();
    rst       = 1'b1;
    pmem_resp = 1'b1;
    step();
    check_eq("stray_busy", {31'h0, arb_busy}, 32'h0);
    check_eq("stray_resps", {30'h0, i_resp, d_resp}, 32'h0);
    step();
    check_eq("stray_busy2", {31'h0, arb_busy}, 32'h0);
    check_eq("stray_strobes", {30'h0, pmem_read, pmem_write}, 32'h0);
    pmem_resp = 1'b0;
    step();

    // d_read and d_write together issue a write
    d_read    = 1'b1;
    d_write   = 1'b1;
    d_address = 32'h10;
    d_wdata   = 32'h55;
    step();
    check_eq("rw_strobes", {30'h0, pmem_read, pmem_write}, 32'h1);
    check_eq("rw_addr", pmem_address, 32'h10);
    d_read  = 1'b0;
    d_write = 1'b0;
    mem_respond(32'h0);
    check_eq("rw_dresp", {31'h0, d_resp}, 32'h1);
    step();
    pmem_resp = 1'b0;
    #1;
    check_eq("rw_done_busy", {31'h0, arb_busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
